// File: rtl/hazard_ctrl.sv
// Central hazard unit for the 5-stage pipeline: stall, forwarding selects and mult/div busy tracking.
// Optional macro HAZARD_STATS_EN adds a saturating stall_cnt output.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] wa_d,
  input  logic [1:0] src_d,
  input  logic       md_start_d,
  input  logic       md_div_d,
  input  logic       md_use_d,
  output logic       stall,
  output logic [2:0] fwd_rs_d,
  output logic [2:0] fwd_rt_d,
  output logic [2:0] fwd_rs_e,
  output logic [2:0] fwd_rt_e,
  output logic [2:0] fwd_rt_m,
  output logic       md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_PC8  = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    src_e       src;
    logic [1:0] tnew;
  } rec_t;

  localparam rec_t E_BUBBLE = '{rs: 5'd0, rt: 5'd0, wa: 5'd0, src: SRC_NONE, tnew: 2'd0};

  // E keeps the full record; M and W only keep what later hazard checks still read.
  rec_t             rec_e, rec_d;
  logic             md_start_e, md_div_e;
  logic [4:0]       rt_m, wa_m, wa_w;
  src_e             src_m, src_w;
  logic [1:0]       tnew_m;
  logic [CNT_W-1:0] md_cnt;
  logic             raw_stall;

  function automatic logic [1:0] tnew_at_e(input src_e s);
    case (s)
      SRC_ALU: return 2'd1;
      SRC_MEM: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic hits(input logic [4:0] a, input logic [4:0] wa, input src_e s);
    return (a != 5'd0) && (wa == a) && (s != SRC_NONE);
  endfunction

  function automatic logic raw_hazard(input logic [4:0] a, input logic [1:0] tuse, input rec_t e,
                                      input logic [4:0] wm, input src_e sm, input logic [1:0] tm);
    return (tuse != 2'd3) &&
           ((hits(a, e.wa, e.src) && (e.tnew > tuse)) || (hits(a, wm, sm) && (tm > tuse)));
  endfunction

  function automatic logic [2:0] sel_d(input logic [4:0] a, input rec_t e,
                                       input logic [4:0] wm, input src_e sm,
                                       input logic [4:0] ww, input src_e sw);
    if (hits(a, e.wa, e.src)) return (e.src == SRC_PC8) ? 3'b001 : 3'b000;
    if (hits(a, wm, sm)) begin
      case (sm)
        SRC_ALU: return 3'b010;
        SRC_PC8: return 3'b011;
        default: return 3'b000;
      endcase
    end
    if (hits(a, ww, sw)) return (sw == SRC_PC8) ? 3'b101 : 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] sel_e(input logic [4:0] a, input logic [4:0] wm, input src_e sm,
                                       input logic [4:0] ww, input src_e sw);
    if (hits(a, wm, sm)) begin
      case (sm)
        SRC_ALU: return 3'b001;
        SRC_PC8: return 3'b010;
        default: return 3'b000;
      endcase
    end
    if (hits(a, ww, sw)) return (sw == SRC_PC8) ? 3'b100 : 3'b011;
    return 3'b000;
  endfunction

  function automatic logic [2:0] sel_m(input logic [4:0] a, input logic [4:0] ww, input src_e sw);
    if (hits(a, ww, sw)) return (sw == SRC_PC8) ? 3'b010 : 3'b001;
    return 3'b000;
  endfunction

  assign md_busy = (md_cnt != '0);

  // NOTE: every variable driven here gets a value before any condition, so no latch can form.
  always_comb begin
    rec_d     = E_BUBBLE;
    rec_d.rs  = rs_d;
    rec_d.rt  = rt_d;
    rec_d.wa  = wa_d;
    rec_d.src = src_e'(src_d);
    rec_d.tnew = tnew_at_e(src_e'(src_d));
    raw_stall = raw_hazard(rs_d, tuse_rs_d, rec_e, wa_m, src_m, tnew_m) ||
                raw_hazard(rt_d, tuse_rt_d, rec_e, wa_m, src_m, tnew_m);
    stall     = raw_stall || (md_use_d && (md_busy || md_start_e));
  end

  assign fwd_rs_d = sel_d(rs_d, rec_e, wa_m, src_m, wa_w, src_w);
  assign fwd_rt_d = sel_d(rt_d, rec_e, wa_m, src_m, wa_w, src_w);
  assign fwd_rs_e = sel_e(rec_e.rs, wa_m, src_m, wa_w, src_w);
  assign fwd_rt_e = sel_e(rec_e.rt, wa_m, src_m, wa_w, src_w);
  assign fwd_rt_m = sel_m(rt_m, wa_w, src_w);

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_e      <= E_BUBBLE;
      md_start_e <= 1'b0;
      md_div_e   <= 1'b0;
      rt_m       <= '0;
      wa_m       <= '0;
      src_m      <= SRC_NONE;
      tnew_m     <= '0;
      wa_w       <= '0;
      src_w      <= SRC_NONE;
    end else begin
      wa_w   <= wa_m;
      src_w  <= src_m;
      rt_m   <= rec_e.rt;
      wa_m   <= rec_e.wa;
      src_m  <= rec_e.src;
      tnew_m <= (rec_e.tnew != 2'd0) ? rec_e.tnew - 2'd1 : 2'd0;
      if (stall) begin
        rec_e      <= E_BUBBLE;
        md_start_e <= 1'b0;
        md_div_e   <= 1'b0;
      end else begin
        rec_e      <= rec_d;
        md_start_e <= md_start_d;
        md_div_e   <= md_div_d;
      end
    end
  end

  // A start sitting in E (re)loads the busy count on the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_start_e) begin
      md_cnt <= md_div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_busy) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cycle table, mult/div sequences, then random traffic
// against a timing-based reference model of the pipeline.
module tb_hazard_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int ALU = 0, MEM = 1, PC8 = 2, NON = 3, U = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, wa_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, src_d;
  logic       md_start_d, md_div_d, md_use_d;
  logic       stall, md_busy;
  logic [2:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .wa_d(wa_d), .src_d(src_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  logic [16:0] outs;
  assign outs = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [16:0] pk(input logic s, input int a, input int b, input int c,
                                     input int d, input int e, input logic bz);
    return {s, a[2:0], b[2:0], c[2:0], d[2:0], e[2:0], bz};
  endfunction

  task automatic drive(input int rs, input int rt, input int tr, input int tt, input int wa,
                       input int src, input bit ms, input bit md, input bit mu);
    rs_d = rs[4:0]; rt_d = rt[4:0]; tuse_rs_d = tr[1:0]; tuse_rt_d = tt[1:0];
    wa_d = wa[4:0]; src_d = src[1:0]; md_start_d = ms; md_div_d = md; md_use_d = mu;
  endtask

  task automatic nop();
    drive(0, 0, U, U, 0, NON, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int rs, rt, tr, tt, wa, src;
    logic [16:0] want;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int rs, input int rt, input int tr, input int tt, input int wa,
                     input int src, input logic [16:0] want);
    vec_t v;
    v.rs = rs; v.rt = rt; v.tr = tr; v.tt = tt; v.wa = wa; v.src = src; v.want = want;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Each in-flight instruction remembers the cycle it sat in E; its result is ready
  // once its latency (ALU 1, MEM 2, else 0) has elapsed since then.
  typedef struct {
    bit v;
    int rs, rt, wa, src;
    bit mds, mdd;
    int ecyc;
  } minst_t;
  minst_t mp[3];
  int now = 0;
  int md_s = 0, md_n = 0;
  bit md_have = 0;

  function automatic int m_tnew(input int k);
    int lat;
    if (!mp[k].v) return 0;
    lat = (mp[k].src == ALU) ? 1 : (mp[k].src == MEM) ? 2 : 0;
    lat = lat - (now - mp[k].ecyc);
    return (lat > 0) ? lat : 0;
  endfunction

  function automatic bit m_hit(input int k, input int a);
    return mp[k].v && a != 0 && mp[k].wa == a && mp[k].src != NON;
  endfunction

  function automatic bit m_raw(input int a, input int tuse);
    if (tuse == U) return 0;
    for (int k = 0; k < 2; k++)
      if (m_hit(k, a) && m_tnew(k) > tuse) return 1;
    return 0;
  endfunction

  function automatic bit m_busy();
    return md_have && now > md_s && now <= md_s + md_n;
  endfunction

  function automatic int m_fwd(input int a, input int first);
    int pc8;
    for (int k = first; k < 3; k++) begin
      if (m_hit(k, a)) begin
        if (m_tnew(k) != 0) return 0;
        pc8 = (mp[k].src == PC8) ? 1 : 0;
        return (first == 0) ? 2 * k + pc8 : 2 * (k - first) + 1 + pc8;
      end
    end
    return 0;
  endfunction

  function automatic logic [16:0] m_expect();
    bit st;
    int ers, ert, mrt;
    st  = m_raw(int'(rs_d), int'(tuse_rs_d)) || m_raw(int'(rt_d), int'(tuse_rt_d)) ||
          (md_use_d && (m_busy() || (mp[0].v && mp[0].mds)));
    ers = mp[0].v ? mp[0].rs : 0;
    ert = mp[0].v ? mp[0].rt : 0;
    mrt = mp[1].v ? mp[1].rt : 0;
    return pk(st, m_fwd(int'(rs_d), 0), m_fwd(int'(rt_d), 0), m_fwd(ers, 1), m_fwd(ert, 1),
              m_fwd(mrt, 2), m_busy());
  endfunction

  task automatic m_step(input bit rst, input bit st);
    if (rst) begin
      for (int k = 0; k < 3; k++) mp[k].v = 0;
      md_have = 0;
    end else begin
      if (mp[0].v && mp[0].mds) begin
        md_have = 1;
        md_s = now;
        md_n = mp[0].mdd ? DIV_N : MULT_N;
      end
      mp[2] = mp[1];
      mp[1] = mp[0];
      if (st) mp[0].v = 0;
      else begin
        mp[0].v = 1; mp[0].rs = int'(rs_d); mp[0].rt = int'(rt_d); mp[0].wa = int'(wa_d);
        mp[0].src = int'(src_d); mp[0].mds = md_start_d; mp[0].mdd = md_div_d;
        mp[0].ecyc = now + 1;
      end
    end
    now++;
  endtask

  initial begin
    int n;
    logic [16:0] want;

    reset = 1'b1;
    nop();
    next_cycle();
    next_cycle();
    reset = 1'b0;

    add(0, 0, U, U, 0, NON,   pk(0, 0, 0, 0, 0, 0, 0));  // reset state
    add(29, 0, 1, U, 8, MEM,  pk(0, 0, 0, 0, 0, 0, 0));  // lw $8
    add(8, 1, 1, 1, 9, ALU,   pk(1, 0, 0, 0, 0, 0, 0));  // addu $9,$8,$1 : load-use
    add(8, 1, 1, 1, 9, ALU,   pk(0, 0, 0, 0, 0, 0, 0));  // lw in M, tnew 1 not > tuse 1
    add(0, 0, U, U, 0, NON,   pk(0, 0, 0, 3, 0, 0, 0));  // lw in W -> E operand 011
    add(2, 3, 1, 1, 8, ALU,   pk(0, 0, 0, 0, 0, 0, 0));  // addu $8
    add(8, 9, 0, 0, 0, NON,   pk(1, 0, 4, 0, 0, 0, 0));  // beq $8,$9
    add(8, 9, 0, 0, 0, NON,   pk(0, 2, 0, 0, 0, 0, 0));  // M&ALU
    add(0, 0, U, U, 31, PC8,  pk(0, 0, 0, 3, 0, 0, 0));  // jal
    add(31, 0, 0, U, 0, NON,  pk(0, 1, 0, 0, 0, 0, 0));  // jr $31 with jal in E
    add(1, 2, 1, 1, 8, ALU,   pk(0, 0, 0, 2, 0, 0, 0));  // addu $8 ; jr in E gets M&PC8
    add(0, 0, 1, U, 8, ALU,   pk(0, 0, 0, 0, 0, 0, 0));  // ori $8
    add(8, 0, 1, 1, 10, ALU,  pk(0, 0, 0, 0, 0, 0, 0));  // E ori wins over M addu
    add(0, 0, U, U, 0, NON,   pk(0, 0, 0, 1, 0, 0, 0));  // M&ALU over W
    add(29, 10, 1, 2, 0, NON, pk(0, 0, 2, 0, 0, 0, 0));  // sw $10
    add(0, 0, U, U, 0, NON,   pk(0, 0, 0, 0, 3, 0, 0));
    add(0, 0, U, U, 31, PC8,  pk(0, 0, 0, 0, 0, 0, 0));  // jal
    add(29, 31, 1, 2, 0, NON, pk(0, 0, 1, 0, 0, 0, 0));  // sw $31
    add(0, 0, U, U, 0, NON,   pk(0, 0, 0, 0, 2, 0, 0));
    add(0, 0, U, U, 0, NON,   pk(0, 0, 0, 0, 0, 2, 0));  // store data from W&PC8
    add(1, 2, 1, 1, 0, ALU,   pk(0, 0, 0, 0, 0, 0, 0));  // writes to $0
    add(3, 4, 1, 1, 0, ALU,   pk(0, 0, 0, 0, 0, 0, 0));
    add(5, 0, 1, U, 0, MEM,   pk(0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, NON,   pk(0, 0, 0, 0, 0, 0, 0));  // reads $0 with $0 writers in E/M/W

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].tr, vecs[i].tt, vecs[i].wa, vecs[i].src, 0, 0, 0);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].want));
      next_cycle();
    end

    // div then mflo: stall for the start cycle plus DIV_N busy cycles
    drive(1, 2, 1, 1, 0, NON, 1, 1, 1);
    @(negedge clk);
    check("div issue stall", 32'(stall), 32'd0);
    next_cycle();
    drive(0, 0, U, U, 3, ALU, 0, 0, 1);
    @(negedge clk);
    check("div start busy", 32'(md_busy), 32'd0);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      next_cycle();
      @(negedge clk);
    end
    check("div stall cycles", 32'(n), 32'(DIV_N + 1));
    check("div busy done", 32'(md_busy), 32'd0);
    next_cycle();

    // mult, then reset in the middle of its busy count
    drive(0, 0, U, U, 0, NON, 1, 0, 1);
    @(negedge clk);
    check("mult issue stall", 32'(stall), 32'd0);
    next_cycle();
    nop();
    next_cycle();
    drive(0, 0, U, U, 3, ALU, 0, 0, 1);
    @(negedge clk);
    check("mult busy", 32'(md_busy), 32'd1);
    check("mfhi stall", 32'(stall), 32'd1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("reset mid-count", 32'(outs), 32'd0);
    next_cycle();

    // random traffic against the model
    reset = 1'b1;
    nop();
    next_cycle();
    reset = 1'b0;
    m_step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      bit ms;
      bit rst;
      ms  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ms, $urandom_range(0, 1) == 1, ms || ($urandom_range(0, 5) == 0));
      reset = rst;
      @(negedge clk);
      want = m_expect();
      check($sformatf("rand%0d", i), 32'(outs), 32'(want));
      m_step(rst, want[16]);
      next_cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
